// File: rtl/centroid_accumulator.sv
// rtl/centroid_accumulator.sv - per-centroid coordinate sums and point counts for k-means update
module centroid_accumulator #(
  parameter int centroid_num     = 8,
  parameter int cordinate_width  = 13,
  parameter int accum_cord_width = 22,
  parameter int accum_width      = 7 * accum_cord_width,
  parameter int dataWidth        = 7 * cordinate_width,
  parameter int count_width      = 10,
  parameter int idx_width        = 3
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   point_valid,
  output logic                   point_ready,
  input  logic [dataWidth-1:0]   point_data,
  input  logic [idx_width-1:0]   point_centroid,
  input  logic                   point_last,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [idx_width-1:0]   out_idx,
  output logic [accum_width-1:0] accumulator,
  output logic [count_width-1:0] counter,
  output logic                   count_overflow,
  output logic                   done
);

  localparam int num_cords = 7;
  localparam logic [count_width-1:0] count_max = '1;
  localparam logic [idx_width-1:0]   last_idx  = idx_width'(centroid_num - 1);

  typedef enum logic [1:0] {IDLE, ACCUM, READOUT, DONE} state_t;

  state_t                               state;
  logic signed [accum_cord_width-1:0]   sum_q   [centroid_num][num_cords];
  logic        [count_width-1:0]        count_q [centroid_num];
  logic        [idx_width-1:0]          rd_ptr;

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      rd_ptr         <= '0;
      point_ready    <= 1'b0;
      out_valid      <= 1'b0;
      done           <= 1'b0;
      count_overflow <= 1'b0;
      for (int s = 0; s < centroid_num; s++) begin
        count_q[s] <= '0;
        for (int k = 0; k < num_cords; k++) sum_q[s][k] <= '0;
      end
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            for (int s = 0; s < centroid_num; s++) begin
              count_q[s] <= '0;
              for (int k = 0; k < num_cords; k++) sum_q[s][k] <= '0;
            end
            count_overflow <= 1'b0;
            rd_ptr         <= '0;
            point_ready    <= 1'b1;
            state          <= ACCUM;
          end
        end
        ACCUM: begin
          if (point_valid && point_ready) begin
            // A saturated counter drops the whole point so sum/count stay consistent
            if (count_q[point_centroid] == count_max) begin
              count_overflow <= 1'b1;
            end else begin
              count_q[point_centroid] <= count_q[point_centroid] + 1'b1;
              for (int k = 0; k < num_cords; k++) begin
                sum_q[point_centroid][k] <= sum_q[point_centroid][k] +
                  accum_cord_width'(signed'(point_data[k*cordinate_width +: cordinate_width]));
              end
            end
            if (point_last) begin
              point_ready <= 1'b0;
              out_valid   <= 1'b1;
              state       <= READOUT;
            end
          end
        end
        READOUT: begin
          if (out_ready) begin
            if (rd_ptr == last_idx) begin
              rd_ptr    <= '0;
              out_valid <= 1'b0;
              done      <= 1'b1;
              state     <= DONE;
            end else begin
              rd_ptr <= rd_ptr + 1'b1;
            end
          end
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign out_idx = rd_ptr;

  // Slot data is only exposed while presenting; otherwise the bus reads zero
  always_comb begin
    accumulator = '0;
    counter     = '0;
    if (out_valid) begin
      for (int k = 0; k < num_cords; k++) begin
        accumulator[k*accum_cord_width +: accum_cord_width] = sum_q[rd_ptr][k];
      end
      counter = count_q[rd_ptr];
    end
  end

endmodule

// File: tb/tb_centroid_accumulator.sv
// tb/tb_centroid_accumulator.sv - randomized bench for centroid_accumulator against an integer model
module tb_centroid_accumulator;

  logic         clk;
  logic         rst;
  logic         start;
  logic         point_valid;
  logic         point_ready;
  logic [90:0]  point_data;
  logic [2:0]   point_centroid;
  logic         point_last;
  logic         out_valid;
  logic         out_ready;
  logic [2:0]   out_idx;
  logic [153:0] accumulator;
  logic [9:0]   counter;
  logic         count_overflow;
  logic         done;

  int passed = 0;
  int total  = 0;

  int msum [8][7];
  int mcnt [8];
  bit movf;
  int cur  [7];

  centroid_accumulator dut (
    .clk(clk), .rst(rst), .start(start),
    .point_valid(point_valid), .point_ready(point_ready),
    .point_data(point_data), .point_centroid(point_centroid), .point_last(point_last),
    .out_valid(out_valid), .out_ready(out_ready), .out_idx(out_idx),
    .accumulator(accumulator), .counter(counter),
    .count_overflow(count_overflow), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: observed no finish, expected finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [159:0] obs, input logic [159:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  function automatic logic [90:0] pack_cur();
    logic [90:0] d;
    for (int k = 0; k < 7; k++) d[k*13 +: 13] = 13'(cur[k]);
    return d;
  endfunction

  function automatic logic [153:0] exp_acc(input int s);
    logic [153:0] r;
    for (int k = 0; k < 7; k++) r[k*22 +: 22] = 22'(msum[s][k]);
    return r;
  endfunction

  task automatic model_clear();
    for (int s = 0; s < 8; s++) begin
      mcnt[s] = 0;
      for (int k = 0; k < 7; k++) msum[s][k] = 0;
    end
    movf = 0;
  endtask

  task automatic rand_cur();
    for (int k = 0; k < 7; k++) cur[k] = int'($urandom_range(0, 8191)) - 4096;
  endtask

  task automatic do_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    model_clear();
    check("start_ready", point_ready, 1);
    check("start_ovf_clr", count_overflow, 0);
  endtask

  // Gap cycles carry junk and a random point_last with valid low; both must be ignored
  task automatic push(input int c, input bit last, input int gap);
    for (int g = 0; g < gap; g++) begin
      point_valid    = 1'b0;
      point_last     = 1'($urandom_range(0, 1));
      point_centroid = 3'($urandom_range(0, 7));
      point_data     = {$urandom, $urandom, $urandom};
      @(negedge clk);
    end
    point_valid    = 1'b1;
    point_last     = last;
    point_centroid = 3'(c);
    point_data     = pack_cur();
    check("point_ready", point_ready, 1);
    if (mcnt[c] == 1023) movf = 1;
    else begin
      mcnt[c]++;
      for (int k = 0; k < 7; k++) msum[c][k] += cur[k];
    end
    @(negedge clk);
    point_valid = 1'b0;
    point_last  = 1'b0;
    if (last) check("readout_latency", out_valid, 1);
  endtask

  task automatic readout(input int mode);
    int e = 0;
    int guard = 0;
    int i = 0;
    bit r;
    check("readout_ovf", count_overflow, movf);
    while (e < 8 && guard < 100) begin
      check("out_valid", out_valid, 1);
      check("out_idx", out_idx, e);
      check("accumulator", accumulator, exp_acc(e));
      check("counter", counter, mcnt[e]);
      check("done_low", done, 0);
      case (mode)
        0:       r = 1'b1;
        1:       r = (i % 3 == 0);
        default: r = 1'($urandom_range(0, 1));
      endcase
      i++;
      out_ready = r;
      @(negedge clk);
      if (r) e++;
      guard++;
    end
    out_ready = 1'b0;
    check("readout_complete", e, 8);
    check("done_pulse", done, 1);
    check("done_out_valid", out_valid, 0);
    @(negedge clk);
    check("done_one_cycle", done, 0);
    check("idle_ready", point_ready, 0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; point_valid = 1'b0; point_data = '0;
    point_centroid = '0; point_last = 1'b0; out_ready = 1'b0;
    model_clear();
    repeat (3) @(negedge clk);
    check("rst_ready", point_ready, 0);
    check("rst_valid", out_valid, 0);
    check("rst_idx", out_idx, 0);
    check("rst_acc", accumulator, 0);
    check("rst_cnt", counter, 0);
    check("rst_ovf", count_overflow, 0);
    check("rst_done", done, 0);
    rst = 1'b0;
    @(negedge clk);
    check("idle_no_ready", point_ready, 0);

    // single point to centroid 3
    do_start();
    for (int k = 0; k < 7; k++) cur[k] = k + 1;
    push(3, 1, 0);
    readout(0);

    // signed sums into centroid 0, with back-pressure on readout
    do_start();
    for (int k = 0; k < 7; k++) cur[k] = -4096;
    push(0, 0, 0);
    for (int k = 0; k < 7; k++) cur[k] = 4095;
    push(0, 0, 0);
    for (int k = 0; k < 7; k++) cur[k] = -1;
    push(0, 1, 0);
    check("signed_acc", accumulator, {7{22'h3FFFFE}});
    check("signed_cnt", counter, 3);
    readout(1);

    // valid gaps, last on the 5th point
    do_start();
    for (int p = 0; p < 5; p++) begin
      rand_cur();
      push(int'($urandom_range(0, 7)), p == 4, int'($urandom_range(0, 3)));
    end
    readout(2);

    // counter overflow on centroid 2
    do_start();
    for (int p = 0; p < 1024; p++) begin
      rand_cur();
      push(2, p == 1023, 0);
    end
    check("ovf_flag", count_overflow, 1);
    readout(0);

    // reset during idx4 presentation, then a fresh pass
    do_start();
    for (int p = 0; p < 20; p++) begin
      rand_cur();
      push(int'($urandom_range(0, 7)), p == 19, int'($urandom_range(0, 1)));
    end
    out_ready = 1'b1;
    repeat (4) @(negedge clk);
    out_ready = 1'b0;
    check("mid_idx4", out_idx, 4);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("mrst_ready", point_ready, 0);
    check("mrst_valid", out_valid, 0);
    check("mrst_idx", out_idx, 0);
    check("mrst_acc", accumulator, 0);
    check("mrst_cnt", counter, 0);
    check("mrst_ovf", count_overflow, 0);
    check("mrst_done", done, 0);
    model_clear();
    @(negedge clk);
    check("mrst_idle", out_valid, 0);
    do_start();
    for (int p = 0; p < 20; p++) begin
      rand_cur();
      push(int'($urandom_range(0, 7)), p == 19, int'($urandom_range(0, 2)));
    end
    readout(2);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/centroid_accumulator.md
Name: centroid_accumulator

Overview:
- Upstream feeder of the per-centroid divider stage in the k-means centroid-update path.
- During one pass over the dataset, it sums the 7 signed coordinates of every classified point into the accumulator of that point's centroid, and counts the points per centroid.
- After the pass, it presents the packed accumulator and count of each centroid in turn (index 0..centroid_num-1) over a valid/ready handshake, for division into new centroid coordinates.

Parameters:
- centroid_num, 8, number of centroids/accumulator slots
- cordinate_width, 13, signed width of one input coordinate
- accum_cord_width, 22, signed width of one accumulated coordinate
- accum_width, 7*22, packed accumulator width (7 coordinates)
- dataWidth, 91, packed point width (7*cordinate_width)
- count_width, 10, per-centroid point counter width
- idx_width, 3, centroid index width (log2 centroid_num)

Ports:
- clk  input  1  clock, all logic on rising edge
- rst  input  1  synchronous active-high reset
- start  input  1  begin new pass; clears all slots
- point_valid  input  1  point_data/point_centroid/point_last valid
- point_ready  output  1  block accepts a point this cycle
- point_data  input  dataWidth  coord k at [(k+1)*13-1 : k*13], k=0..6, two's complement
- point_centroid  input  idx_width  centroid the point is classified to
- point_last  input  1  final point of pass; qualified by valid&ready
- out_valid  output  1  accumulator/counter/out_idx valid
- out_ready  input  1  downstream consumes current centroid
- out_idx  output  idx_width  centroid index being presented
- accumulator  output  accum_width  packed sums, coord k at [(k+1)*22-1 : k*22]
- counter  output  count_width  points summed into this centroid
- count_overflow  output  1  sticky: a point was dropped due to full counter
- done  output  1  one-cycle pulse after last centroid handed off

Behaviour:
- Reset (rst=1 at clock edge): state=IDLE, all slot sums/counts=0, rd_ptr=0. Outputs point_ready=0, out_valid=0, out_idx=0, accumulator=0, counter=0, count_overflow=0, done=0. rst has priority over all inputs in any state, including mid-ACCUM or mid-READOUT.
- FSM states: IDLE, ACCUM, READOUT, DONE.
- IDLE:
  - point_ready=0, out_valid=0.
  - start=1 -> clear all sums/counts, clear count_overflow, rd_ptr=0, go to ACCUM next cycle.
- ACCUM:
  - point_ready=1; start is ignored.
  - A point is accepted on point_valid & point_ready.
  - For slot s=point_centroid, each coord is sign-extended 13->22 and added to sum[s][k]; count[s]+1. The update is visible from the next cycle.
  - Sums wrap modulo 2^22; there is no saturation. Callers bound the dataset so this cannot happen (<=512 full-scale points per centroid).
  - If count[s]==2^count_width-1 when a point is accepted: the point is discarded, sum and count are unchanged, and count_overflow is set. It stays set until the next start or rst.
  - An accepted point with point_last=1 is processed as above, and the state moves to READOUT next cycle.
  - point_last without an accept has no effect.
- READOUT:
  - point_ready=0, out_valid=1, out_idx=rd_ptr.
  - accumulator and counter are driven from slot rd_ptr and are stable while out_valid & !out_ready.
  - On out_valid & out_ready: if rd_ptr<centroid_num-1, rd_ptr+1; otherwise rd_ptr=0 and go to DONE.
  - Empty centroids (counter=0) are still presented. The divider flags divide-by-zero and downstream keeps the old centroid.
  - Throughput: one centroid per cycle with out_ready held high, so 8 cycles minimum.
  - start is ignored.
- DONE: done=1 for exactly one cycle, out_valid=0, then go to IDLE. Slot contents are retained until the next start.
- Latency: last point accepted at cycle N gives out_valid=1 at N+1. Last handshake at cycle M gives done=1 at M+1.

Test Plan:
- Single point: start; point (1,2,3,4,5,6,7) to centroid 3 with last=1 -> idx3 accumulator coords=1..7 and counter=1; all other idx have zeros and counter=0; 8 outputs with out_idx 0..7 in order; done pulses once.
- Signed sums: centroid 0 gets coords -4096, +4095, -1 (all 7 coords equal per point) -> each coord sum=-2 (0x3FFFFE), counter=3.
- Back-pressure: out_ready toggles 1,0,0,1,... -> out_idx and data hold while out_ready=0; no index skipped or repeated; done follows idx7 handshake by one cycle.
- Point valid/ready gaps: point_valid low for random cycles, last sent on the 5th point -> exactly 5 points summed; point_last with point_valid=0 is ignored.
- Counter overflow: 1024 points to centroid 2 -> counter=1023, the 1024th point excluded from the sums, count_overflow=1; next start clears it.
- Reset mid-readout: rst during idx4 presentation -> next cycle all outputs 0, state IDLE; new start pass produces correct fresh sums with no residue.
